// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/bubble constants, fetch states and
// the IF/ID pipeline-register payload.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc_next;
        logic [31:0] instruction;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a bubble load beats a normal load, otherwise it
// holds its contents.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t payload,
    output if_id_t if_id
);

    if_id_t bubble_word;

    assign bubble_word = '{pc_next: 32'h0, instruction: NOP_INSTR, valid: 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id <= bubble_word;
        end else if (bubble) begin
            if_id <= bubble_word;
        end else if (load) begin
            if_id <= payload;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem handshake FSM with a one-word
// skid buffer for words returned while the pipeline is held, and IF/ID.
//
// state | meaning
// FETCH | imem_req high, fetching the word at pc
// HOLD  | word at pc already captured in skid_buf, waiting for hold to clear
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = mips_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        pc_stall,
    input  logic        if_id_stall,
    input  logic        flush,
    input  logic [31:0] pc_decode,
    output logic [31:0] if_id_pc_next,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic [31:0] pc
);

    fetch_state_t state;
    logic [31:0]  skid_buf;
    logic [31:0]  pc_plus4;
    logic         hold;
    logic         ifid_load;
    logic         ifid_bubble;
    if_id_t       payload;
    if_id_t       if_id;

    assign hold     = pc_stall | if_id_stall;
    assign pc_plus4 = pc + 32'd4;

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // A pending hold masks flush: decode re-evaluates the branch after the stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            skid_buf <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (!hold) begin
                        if (flush) begin
                            pc <= pc_decode;
                        end else if (imem_ready) begin
                            pc <= pc_plus4;
                        end
                    end else if (imem_ready) begin
                        skid_buf <= imem_rdata;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        pc    <= flush ? pc_decode : pc_plus4;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign ifid_bubble = !hold && (flush || (state == FETCH && !imem_ready));
    assign ifid_load   = !hold && !flush && (state == HOLD || imem_ready);

    assign payload = '{
        pc_next:     pc_plus4,
        instruction: (state == HOLD) ? skid_buf : imem_rdata,
        valid:       1'b1
    };

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .payload(payload),
        .if_id  (if_id)
    );

    assign if_id_pc_next     = if_id.pc_next;
    assign if_id_instruction = if_id.instruction;
    assign if_id_valid       = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-HOLD sequence and a
// randomized run against a queue-based behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        pc_stall;
    logic        if_id_stall;
    logic        flush;
    logic [31:0] pc_decode;
    logic [31:0] if_id_pc_next;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .pc_stall         (pc_stall),
        .if_id_stall      (if_id_stall),
        .flush            (flush),
        .pc_decode        (pc_decode),
        .if_id_pc_next    (if_id_pc_next),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid),
        .pc               (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h5A5A_00F1;
    endfunction

    // Memory image: combinational read of the requested address.
    assign imem_rdata = w(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic e_req,
                           input logic [31:0] e_pcn, input logic [31:0] e_ins, input logic e_val);
        chk({tag, ".addr"}, imem_addr, e_addr);
        chk({tag, ".pc"}, pc, e_addr);
        chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, e_req});
        chk({tag, ".pc_next"}, if_id_pc_next, e_pcn);
        chk({tag, ".instr"}, if_id_instruction, e_ins);
        chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_val});
    endtask

    typedef struct {
        logic        r, ps, is, fl;
        logic [31:0] pd;
        logic [31:0] addr;
        logic        req;
        logic [31:0] pcn, ins;
        logic        val;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic r, ps, is, fl, input logic [31:0] pd,
                                input logic [31:0] addr, input logic req,
                                input logic [31:0] pcn, ins, input logic val);
        vec_t v;
        v.r = r; v.ps = ps; v.is = is; v.fl = fl; v.pd = pd;
        v.addr = addr; v.req = req; v.pcn = pcn; v.ins = ins; v.val = val;
        return v;
    endfunction

    task automatic drive(input logic r, ps, is, fl, input logic [31:0] pd);
        imem_ready  = r;
        pc_stall    = ps;
        if_id_stall = is;
        flush       = fl;
        pc_decode   = pd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Behavioural model: the pipeline delivers the word at m_pc once, either
    // straight from memory or from a word captured while held.
    logic [31:0] m_pc, m_pcn, m_ins;
    logic        m_val;
    logic [31:0] pending[$];

    task automatic model_step(input logic r, hold, fl, input logic [31:0] pd);
        if (hold) begin
            if (pending.size() == 0 && r) pending.push_back(w(m_pc));
        end else if (fl) begin
            m_pc = pd;
            m_pcn = 32'h0; m_ins = NOP; m_val = 1'b0;
            pending.delete();
        end else if (pending.size() != 0) begin
            m_ins = pending.pop_front();
            m_pcn = m_pc + 32'd4; m_val = 1'b1; m_pc = m_pc + 32'd4;
        end else if (r) begin
            m_ins = w(m_pc);
            m_pcn = m_pc + 32'd4; m_val = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
            m_pcn = 32'h0; m_ins = NOP; m_val = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        chk_all("reset", RST_PC, 1'b1, 32'h0, NOP, 1'b0);

        // cols: ready pc_stall if_id_stall flush pc_decode | addr req pc_next instr valid
        vecs[0]  = mk(1,0,0,0,32'h0,  32'h0,  1, 32'h0,  NOP,      0);
        vecs[1]  = mk(1,0,0,0,32'h0,  32'h4,  1, 32'h4,  w(32'h0), 1);
        vecs[2]  = mk(1,0,0,0,32'h0,  32'h8,  1, 32'h8,  w(32'h4), 1);
        vecs[3]  = mk(0,0,0,0,32'h0,  32'hC,  1, 32'hC,  w(32'h8), 1);
        vecs[4]  = mk(0,0,0,0,32'h0,  32'hC,  1, 32'h0,  NOP,      0);
        vecs[5]  = mk(1,0,0,0,32'h0,  32'hC,  1, 32'h0,  NOP,      0);
        vecs[6]  = mk(1,1,1,0,32'h0,  32'h10, 1, 32'h10, w(32'hC), 1);
        vecs[7]  = mk(1,1,1,0,32'h0,  32'h10, 0, 32'h10, w(32'hC), 1);
        vecs[8]  = mk(1,1,1,1,32'h80, 32'h10, 0, 32'h10, w(32'hC), 1);
        vecs[9]  = mk(1,0,0,0,32'h0,  32'h10, 0, 32'h10, w(32'hC), 1);
        vecs[10] = mk(1,0,0,1,32'h40, 32'h14, 1, 32'h14, w(32'h10),1);
        vecs[11] = mk(1,0,0,0,32'h0,  32'h40, 1, 32'h0,  NOP,      0);
        vecs[12] = mk(1,0,0,0,32'h0,  32'h44, 1, 32'h44, w(32'h40),1);
        vecs[13] = mk(1,0,1,1,32'h80, 32'h48, 1, 32'h48, w(32'h44),1);
        vecs[14] = mk(1,0,0,1,32'h80, 32'h48, 0, 32'h48, w(32'h44),1);
        vecs[15] = mk(1,0,0,0,32'h0,  32'h80, 1, 32'h0,  NOP,      0);
        vecs[16] = mk(1,0,0,0,32'h0,  32'h84, 1, 32'h84, w(32'h80),1);
        vecs[17] = mk(0,1,0,0,32'h0,  32'h88, 1, 32'h88, w(32'h84),1);
        vecs[18] = mk(1,0,0,0,32'h0,  32'h88, 1, 32'h88, w(32'h84),1);
        vecs[19] = mk(1,0,0,0,32'h0,  32'h8C, 1, 32'h8C, w(32'h88),1);
        vecs[20] = mk(1,0,0,1,32'hFFFF_FFFC, 32'h90, 1, 32'h90, w(32'h8C), 1);
        vecs[21] = mk(1,0,0,0,32'h0,  32'hFFFF_FFFC, 1, 32'h0, NOP, 0);
        vecs[22] = mk(1,0,0,0,32'h0,  32'h0,  1, 32'h0,  w(32'hFFFF_FFFC), 1);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].r, vecs[i].ps, vecs[i].is, vecs[i].fl, vecs[i].pd);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].req,
                    vecs[i].pcn, vecs[i].ins, vecs[i].val);
            @(negedge clk);
        end

        // Reset while in HOLD: captured word at 0x4 must never surface.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("hold_entry.req", {31'h0, imem_req}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst_in_hold", RST_PC, 1'b1, 32'h0, NOP, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk_all("post_rst", RST_PC, 1'b1, 32'h0, NOP, 1'b0);
        @(negedge clk);
        #1;
        chk_all("post_rst_fetch", 32'h4, 1'b1, 32'h4, w(32'h0), 1'b1);

        // Randomized run against the model.
        do_reset();
        m_pc = RST_PC; m_pcn = 32'h0; m_ins = NOP; m_val = 1'b0;
        pending.delete();
        for (int c = 0; c < 400; c++) begin
            logic r, ps, is, fl;
            logic [31:0] pd;
            r  = ($urandom_range(3) != 0);
            ps = ($urandom_range(5) == 0);
            is = ($urandom_range(5) == 0);
            fl = ($urandom_range(6) == 0);
            pd = {$urandom_range(16'hFFFF), 14'h0, 2'b00} | {16'h0, $urandom_range(16'h3FFF), 2'b00};
            drive(r, ps, is, fl, pd);
            #1;
            chk_all($sformatf("rand%0d", c), m_pc, (pending.size() == 0),
                    m_pcn, m_ins, m_val);
            model_step(r, ps | is, fl, pd);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC, drives the instruction-memory request/ready handshake and holds the IF/ID pipeline register consumed by decode. It consumes the decode stage's redirect (`flush`, `pc_decode`) and the hazard unit's stall requests (`pc_stall`, `if_id_stall`). It supplies `if_id_pc_next` (PC+4) and `if_id_instruction` to decode's register file, control unit and branch/jump address logic.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000, instruction word inserted as a bubble.

- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request, asserted in state FETCH.
- `imem_addr`  out  32  fetch address, always equal to `pc`.
- `imem_ready`  in  1  `imem_rdata` is valid for `imem_addr` this cycle; may be combinational from `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `pc_stall`  in  1  hazard unit: hold PC.
- `if_id_stall`  in  1  hazard unit: hold IF/ID.
- `flush`  in  1  decode: jump or taken branch.
- `pc_decode`  in  32  decode: redirect target.
- `if_id_pc_next`  out  32  registered PC+4 of the held instruction.
- `if_id_instruction`  out  32  registered instruction.
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.
- `pc`  out  32  current fetch PC.

## Operation
- Stall condition: `hold = pc_stall | if_id_stall`.
- `hold` has priority over `flush`. While `hold` = 1, `flush` is ignored, because decode re-evaluates the branch once the stall clears.
- The FSM has two states, FETCH and HOLD. The 32-bit skid buffer `buf` is written only on the FETCH→HOLD transition.

FETCH (`imem_req` = 1):
- `flush` & !`hold`:
  - `pc` <= `pc_decode`.
  - IF/ID <= bubble.
  - Any `imem_rdata` this cycle is discarded.
  - State stays FETCH.
- `imem_ready` & !`hold` & !`flush`:
  - IF/ID <= {`pc`+4, `imem_rdata`, valid = 1}.
  - `pc` <= `pc`+4.
- !`imem_ready` & !`hold` & !`flush`:
  - IF/ID <= bubble.
  - `pc` holds.
- `imem_ready` & `hold`:
  - `buf` <= `imem_rdata`.
  - State → HOLD.
  - IF/ID and `pc` hold.
- !`imem_ready` & `hold`: everything holds.

HOLD (`imem_req` = 0):
- `hold`: everything holds.
- !`hold` & !`flush`:
  - IF/ID <= {`pc`+4, `buf`, valid = 1}.
  - `pc` <= `pc`+4.
  - State → FETCH.
- !`hold` & `flush`:
  - `pc` <= `pc_decode`.
  - IF/ID <= bubble.
  - `buf` is discarded.
  - State → FETCH.

Common rules:
- A bubble is {`if_id_pc_next` = 0, `if_id_instruction` = `NOP_INSTR`, `if_id_valid` = 0}.
- `pc`+4 wraps modulo 2^32.
- `pc_decode` is used as-is; its low bits are not checked.
- Memory holds no outstanding transactions. A change of `imem_addr` while `imem_req` = 1 abandons the old fetch.

## Timing
- Reset (asynchronous):
  - `pc` = `RESET_PC`, state = FETCH, `buf` = 0.
  - IF/ID = bubble, so `if_id_valid` = 0, `if_id_instruction` = `NOP_INSTR`, `if_id_pc_next` = 0.
  - `imem_req` = 1 and `imem_addr` = `RESET_PC` in the first cycle after release.
- Throughput is one instruction per cycle with zero-wait memory. Latency is 1 cycle from `imem_ready` to valid IF/ID.
- Each memory wait cycle inserts one bubble.
- Flush penalty:
  - Exactly one bubble.
  - The target is requested in the cycle after `flush`.
  - It appears in IF/ID in the cycle after that, given `imem_ready`.
- During a stall:
  - IF/ID outputs are stable for every cycle `hold` = 1.
  - The first instruction after release is the buffered or re-fetched `pc` word; nothing is lost or duplicated.
- Reset asserted mid-stall or in HOLD returns to the reset state immediately, and `buf` is cleared.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INSTR` constant.
  - Default `RESET_PC`.
  - Fetch state enum {FETCH, HOLD}.
  - `if_id_t` struct {pc_next[31:0], instruction[31:0], valid}.
- Sub-module `if_id_reg` is the IF/ID register.
  - Inputs: `load`, `bubble`, payload.
  - Asynchronous reset to bubble.
  - Priority: `bubble` over `load`; otherwise hold.
- The FSM, PC register and skid buffer live in `fetch_stage`.

## Test plan
- Reset release, `imem_ready` tied 1, words A,B,C at 0x0/0x4/0x8 → `imem_addr` 0x0,0x4,0x8 on consecutive cycles; IF/ID shows {0x4,A,1},{0x8,B,1},{0xC,C,1}.
- `imem_ready` low 2 cycles at PC 0x4 → `imem_addr` stays 0x4; two bubbles (valid = 0, instruction = `NOP_INSTR`); then {0x8,B,1}.
- `pc_stall` = `if_id_stall` = 1 for 3 cycles while fetching 0x8 with ready = 1 → FSM enters HOLD, `imem_req` = 0, IF/ID frozen at {0x8,B,1}; on release IF/ID = {0xC,C,1} from `buf`, next `imem_addr` = 0xC.
- `flush` = 1, `pc_decode` = 0x40 at PC 0x8 → next cycle `imem_addr` = 0x40 and IF/ID = bubble; following cycle IF/ID = {0x44, word@0x40, 1}.
- `flush` and `if_id_stall` together → flush ignored, PC unchanged; `flush` asserted after stall release redirects normally.
- Reset asserted while in HOLD → `pc` = `RESET_PC`, IF/ID = bubble, state = FETCH immediately; `buf` contents never appear in IF/ID.
